// File: rtl/lc3_pkg.sv
// Shared LC3 types: data-memory request codes, responder FSM states and the ISA opcodes
// shared with the pipeline controller.
package lc3_pkg;

    typedef enum logic [1:0] {
        MS_READ  = 2'd0,
        MS_IND   = 2'd1,
        MS_WRITE = 2'd2,
        MS_IDLE  = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_BUSY = 2'd1,
        RS_DONE = 2'd2
    } resp_state_t;

    typedef enum logic [3:0] {
        OP_BR   = 4'd0,
        OP_ADD  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_JSR  = 4'd4,
        OP_AND  = 4'd5,
        OP_LDR  = 4'd6,
        OP_STR  = 4'd7,
        OP_RTI  = 4'd8,
        OP_NOT  = 4'd9,
        OP_LDI  = 4'd10,
        OP_STI  = 4'd11,
        OP_JMP  = 4'd12,
        OP_RES  = 4'd13,
        OP_LEA  = 4'd14,
        OP_TRAP = 4'd15
    } lc3_opcode_t;

endpackage

// File: rtl/lc3_dmem_array.sv
// Single-port 2^ADDR_W x 16 data store: one write port, one registered read.
// Only the read register is reset; the store contents survive reset.
module lc3_dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       din_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      rdata_o <= 16'h0000;
        else if (re_i) rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/lc3_dmem_responder.sv
// Data-memory responder: services read / indirect / write requests from the LC3 controller
// after LATENCY busy cycles and signals the end of each access with a one-cycle pulse.
module lc3_dmem_responder
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_state,
    input  logic [15:0]       M_Addr,
    input  logic [15:0]       M_Din,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [15:0]       init_din,
    output logic [15:0]       Data_dout,
    output logic              complete_data,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    resp_state_t       state_q;
    logic [3:0]        cnt_q;
    logic              wr_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q;

    logic              req, bd_we;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^M_Addr[15:ADDR_W];

    assign req   = (state_q == RS_IDLE) && (mem_state != MS_IDLE);
    assign bd_we = (state_q == RS_IDLE) && (mem_state == MS_IDLE) && init_we;

    // The RAM's read register is Data_dout, so reads are launched on the edge that enters DONE;
    // with zero latency that edge is the request edge itself, hence the live address.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        ram_din  = din_q;
        case (state_q)
            RS_IDLE: begin
                if (bd_we) begin
                    ram_we   = 1'b1;
                    ram_addr = init_addr;
                    ram_din  = init_din;
                end else if (req && LATENCY == 0 && mem_state != MS_WRITE) begin
                    ram_re   = 1'b1;
                    ram_addr = M_Addr[ADDR_W-1:0];
                end
            end
            RS_BUSY: ram_re = (cnt_q == 4'd0) && !wr_op_q;
            RS_DONE: ram_we = wr_op_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RS_IDLE;
            cnt_q         <= 4'd0;
            wr_op_q       <= 1'b0;
            addr_q        <= '0;
            din_q         <= 16'h0000;
            complete_data <= 1'b0;
            busy          <= 1'b0;
        end else begin
            complete_data <= 1'b0;
            case (state_q)
                RS_IDLE: begin
                    if (req) begin
                        wr_op_q <= (mem_state == MS_WRITE);
                        addr_q  <= M_Addr[ADDR_W-1:0];
                        din_q   <= M_Din;
                        cnt_q   <= LAT_M1;
                        busy    <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q       <= RS_DONE;
                            complete_data <= 1'b1;
                        end else begin
                            state_q <= RS_BUSY;
                        end
                    end
                end
                RS_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q       <= RS_DONE;
                        complete_data <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RS_DONE: begin
                    state_q <= RS_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= RS_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    lc3_dmem_array #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .din_i   (ram_din),
        .rdata_o (Data_dout)
    );

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: three instances (LATENCY 0, 2, 4) share stimulus; each check
// targets one instance. Directed table, hand-written corner sequences, then random ops vs a word-array model.
module tb_lc3_dmem_responder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mem_state = 2'd3;
    logic [15:0]   M_Addr = 16'h0;
    logic [15:0]   M_Din = 16'h0;
    logic          init_we = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [15:0]   init_din = 16'h0;
    logic [15:0]   dout [3];
    logic          cmp  [3];
    logic          bsy  [3];

    int tests = 0;
    int fails = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    lc3_dmem_responder #(.ADDR_W(AW), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .mem_state(mem_state), .M_Addr(M_Addr), .M_Din(M_Din),
        .init_we(init_we), .init_addr(init_addr), .init_din(init_din),
        .Data_dout(dout[0]), .complete_data(cmp[0]), .busy(bsy[0]));
    lc3_dmem_responder #(.ADDR_W(AW), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .mem_state(mem_state), .M_Addr(M_Addr), .M_Din(M_Din),
        .init_we(init_we), .init_addr(init_addr), .init_din(init_din),
        .Data_dout(dout[1]), .complete_data(cmp[1]), .busy(bsy[1]));
    lc3_dmem_responder #(.ADDR_W(AW), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .mem_state(mem_state), .M_Addr(M_Addr), .M_Din(M_Din),
        .init_we(init_we), .init_addr(init_addr), .init_din(init_din),
        .Data_dout(dout[2]), .complete_data(cmp[2]), .busy(bsy[2]));

    function automatic int lat_of(input int idx);
        return idx * 2;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        mem_state = 2'd3;
        init_we   = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_state = 2'd3;
        init_we   = 1'b1;
        init_addr = a;
        init_din  = d;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    // Issue one request, optionally scrambling all inputs while it is in flight, and check
    // completion latency, busy coverage and a one-cycle pulse. Returns Data_dout at the pulse.
    task automatic issue(input int idx, input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] din, input bit garb, input string name,
                         output logic [15:0] got);
        int n;
        bit busy_ok;
        @(negedge clk);
        mem_state = op;
        M_Addr    = addr;
        M_Din     = din;
        init_we   = 1'b0;
        @(posedge clk);
        #1;
        n = 1;
        busy_ok = 1'b1;
        while (cmp[idx] !== 1'b1 && n < 40) begin
            if (bsy[idx] !== 1'b1) busy_ok = 1'b0;
            mem_state = 2'd3;
            if (garb) begin
                mem_state = 2'($urandom);
                M_Addr    = 16'($urandom);
                M_Din     = 16'($urandom);
                init_we   = 1'b1;
                init_addr = 8'h41;
                init_din  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        got = dout[idx];
        chk({name, " latency"}, 16'(n), 16'(lat_of(idx) + 1));
        chk({name, " busy"}, {15'b0, busy_ok & bsy[idx]}, 16'd1);
        mem_state = 2'd3;
        init_we   = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " pulse/busy after"}, {14'b0, cmp[idx], bsy[idx]}, 16'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [10];
        logic [15:0] got, last, v;
        logic [7:0]  a;
        logic [1:0]  op;
        bit          have, saw;

        tbl[0] = '{2'd0, 16'h0005, 16'h0000, 16'hBEEF};
        tbl[1] = '{2'd2, 16'h0030, 16'h1111, 16'hBEEF};
        tbl[2] = '{2'd0, 16'h0030, 16'h0000, 16'h1111};
        tbl[3] = '{2'd2, 16'h0031, 16'h2222, 16'h1111};
        tbl[4] = '{2'd1, 16'h0031, 16'h0000, 16'h2222};
        tbl[5] = '{2'd2, 16'h00FF, 16'hFFFF, 16'h2222};
        tbl[6] = '{2'd0, 16'h01FF, 16'h0000, 16'hFFFF};
        tbl[7] = '{2'd2, 16'hAB00, 16'h0001, 16'hFFFF};
        tbl[8] = '{2'd1, 16'h0100, 16'h0000, 16'h0001};
        tbl[9] = '{2'd0, 16'h0030, 16'h0000, 16'h1111};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dout%0d", i), dout[i], 16'h0000);
            chk($sformatf("reset complete%0d", i), {15'b0, cmp[i]}, 16'd0);
            chk($sformatf("reset busy%0d", i), {15'b0, bsy[i]}, 16'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        settle();
        bd_write(8'h05, 16'hBEEF);
        bd_write(8'h10, 16'h0020);
        bd_write(8'h40, 16'h4040);
        bd_write(8'h41, 16'h4141);

        // basic read, LATENCY 2
        issue(1, 2'd0, 16'h0005, 16'h0, 1'b0, "basic read", got);
        chk("basic read data", got, 16'hBEEF);

        for (int i = 0; i < 10; i++) begin
            issue(1, tbl[i].op, tbl[i].addr, tbl[i].din, 1'b0, $sformatf("tbl%0d", i), got);
            chk($sformatf("tbl%0d dout", i), got, tbl[i].exp);
        end

        // write then read back-to-back, LATENCY 0
        settle();
        issue(0, 2'd2, 16'h000A, 16'h1234, 1'b0, "raw write", got);
        issue(0, 2'd0, 16'h000A, 16'h0, 1'b0, "raw read", got);
        chk("raw read data", got, 16'h1234);

        // indirect store sequence, LATENCY 2
        settle();
        issue(1, 2'd1, 16'h0010, 16'h0, 1'b0, "ind addr", got);
        chk("ind addr data", got, 16'h0020);
        issue(1, 2'd2, 16'h0020, 16'h00FF, 1'b0, "ind store", got);
        chk("ind store dout hold", got, 16'h0020);
        issue(1, 2'd0, 16'h0020, 16'h0, 1'b0, "ind verify", got);
        chk("ind verify data", got, 16'h00FF);

        // inputs scrambled and init_we held while busy
        settle();
        issue(1, 2'd0, 16'h0040, 16'h0, 1'b1, "stable", got);
        chk("stable data", got, 16'h4040);
        issue(1, 2'd0, 16'h0041, 16'h0, 1'b0, "dropped bd", got);
        chk("dropped bd data", got, 16'h4141);

        // reset in the second busy cycle of a write, LATENCY 4
        settle();
        bd_write(8'h03, 16'h5555);
        @(negedge clk);
        mem_state = 2'd2;
        M_Addr    = 16'h0003;
        M_Din     = 16'hAAAA;
        @(posedge clk);
        #1;
        mem_state = 2'd3;
        chk("rst first busy", {15'b0, bsy[2]}, 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst dout", dout[2], 16'h0000);
        chk("rst complete/busy", {14'b0, cmp[2], bsy[2]}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cmp[2] !== 1'b0 || bsy[2] !== 1'b0) saw = 1'b1;
        end
        chk("rst no late pulse", {15'b0, saw}, 16'd0);
        issue(2, 2'd0, 16'h0003, 16'h0, 1'b0, "rst store kept", got);
        chk("rst store kept data", got, 16'h5555);

        // random traffic against a word-array model, every latency
        for (int d = 0; d < 3; d++) begin
            settle();
            for (int i = 0; i < 256; i++) begin
                model[i] = 16'($urandom);
                bd_write(8'(i), model[i]);
            end
            have = 1'b0;
            last = 16'h0;
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(3) == 0) begin
                    a = 8'($urandom);
                    v = 16'($urandom);
                    bd_write(a, v);
                    model[a] = v;
                end
                op = (k == 0) ? 2'd0 : 2'($urandom_range(2));
                a  = 8'($urandom);
                v  = 16'($urandom);
                issue(d, op, {8'($urandom), a}, v, 1'($urandom_range(1)),
                      $sformatf("rnd L%0d #%0d", lat_of(d), k), got);
                if (op == 2'd2) begin
                    model[a] = v;
                    if (have) chk($sformatf("rnd L%0d #%0d hold", lat_of(d), k), got, last);
                end else begin
                    last = model[a];
                    have = 1'b1;
                    chk($sformatf("rnd L%0d #%0d read @%h", lat_of(d), k, a), got, last);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lc3_dmem_responder.md
# lc3_dmem_responder

Memory-side responder for the LC3 pipeline's data-memory handshake. It watches the controller's `mem_state` request code, performs the requested read, indirect-address read or write against a word-addressed data store after a programmable latency, and returns `Data_dout` with a one-cycle `complete_data` pulse. It sits between the MemAccess stage and the data RAM and is the counterpart of the controller's stall logic.

## Interface
Parameters:
- `ADDR_W`, default 8: store depth is 2^ADDR_W words; only `M_Addr[ADDR_W-1:0]` is used.
- `LATENCY`, default 2: number of BUSY cycles per access. Legal range is 0..15.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_state`  in  2  request code: 0 = read data, 1 = read indirect address, 2 = write, 3 = idle.
- `M_Addr`  in  16  access address.
- `M_Din`  in  16  write data; used only when `mem_state` = 2.
- `init_we`  in  1  back-door load strobe used for program/data preload.
- `init_addr`  in  ADDR_W  back-door load address.
- `init_din`  in  16  back-door load data.
- `Data_dout`  out  16  read result; holds its value until the next read completes.
- `complete_data`  out  1  one-cycle pulse marking the end of an access.
- `busy`  out  1  high when the FSM is in BUSY or DONE.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE.** When `mem_state` != 3:
  - capture the op, `M_Addr` and `M_Din`;
  - load the counter with `LATENCY-1`;
  - go to BUSY, or go straight to DONE if `LATENCY` = 0.
- **BUSY.** If the counter is 0, go to DONE; otherwise decrement the counter.
- **DONE.**
  - Assert `complete_data` for this cycle only.
  - Read ops (0 and 1): `Data_dout` is updated at the edge entering DONE with the stored word at the captured address.
  - Write op (2): the captured `M_Din` is written to the captured address at the edge leaving DONE.
  - Always return to IDLE. The op code is not re-sampled in DONE.
- Op 1 and op 0 behave identically at this block. The controller sequences indirect accesses (1 then 0 for loads, 1 then 2 for stores) as separate requests.
- Inputs are ignored while BUSY or DONE; the captured values are used. Changing `mem_state` mid-access is legal and has no effect.
- Back-door load: `init_we` writes `init_din` to `init_addr` only when the FSM is IDLE and `mem_state` = 3. Otherwise it is dropped.
- Read-after-write: a read issued right after a write to the same address returns the new data.
- **Reset** (async, mid-access included):
  - FSM goes to IDLE and the counter to 0;
  - `Data_dout` = 16'h0000, `complete_data` = 0, `busy` = 0;
  - an in-flight write is abandoned;
  - store contents are not cleared.

## Timing
- All outputs are registered.
- A request sampled in IDLE at edge T gives `complete_data` high during cycle T+LATENCY+1 (cycle T+1 when `LATENCY` = 0).
- `Data_dout` is valid in that same cycle.
- The cycle after DONE is always IDLE, so the minimum issue interval is LATENCY+2 cycles.
- A new request is accepted in the IDLE cycle immediately after DONE if `mem_state` != 3 there.

## Structure
- Shared package `lc3_pkg` holds:
  - the `mem_state_t` enum: `MS_READ` = 0, `MS_IND` = 1, `MS_WRITE` = 2, `MS_IDLE` = 3;
  - the responder state enum (IDLE, BUSY, DONE);
  - the LC3 opcode enum, shared with the controller.
- Sub-module `lc3_dmem_array`: a single-port synchronous RAM, 2^ADDR_W × 16, with one write port and one registered read.
  - The responder muxes the back-door port and the request port onto it.

## Test plan
- **Basic read.** `LATENCY` = 2, preload [0x05] = 16'hBEEF, `mem_state` = 0 and `M_Addr` = 0x0005 at edge T → `complete_data` high only in cycle T+3 with `Data_dout` = 16'hBEEF.
- **Write then read.** `LATENCY` = 0, write 16'h1234 to 0x0A, then read 0x0A in the next IDLE cycle → the read's `complete_data` pulse shows `Data_dout` = 16'h1234; each pulse is exactly one cycle wide.
- **Indirect store sequence.** Preload [0x10] = 16'h0020. Issue `mem_state` 1 @ 0x10; on its completion issue 2 @ 0x20 with `M_Din` = 16'h00FF → two completions; [0x20] = 16'h00FF; `Data_dout` = 16'h0020 after the first access.
- **Reset mid-access.** Start a write of 16'hAAAA to 0x03 with `LATENCY` = 4, pull `rst` low in the second BUSY cycle → all outputs 0 immediately; [0x03] keeps its old value; no pulse after reset releases.
- **Stability and dropped back-door load.** Change `M_Addr` and `mem_state` every cycle while BUSY, and assert `init_we` during BUSY → the captured address is the one serviced, the `init_we` write does not occur, and `busy` stays high throughout BUSY and DONE.
